// File: rtl/boot_ctrl_pkg.sv
// Shared definitions for the boot/run controller: state encoding, default
// instruction constants and the port-A write/read enable encoding.
`ifndef MM_ENB_W
`define MM_ENB_W 1'b1
`endif
`ifndef MM_ENB_R
`define MM_ENB_R 1'b0
`endif

package boot_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_TERM = 3'd2,
    ST_RUN  = 3'd3,
    ST_DONE = 3'd4
  } boot_state_e;

  localparam logic [31:0] HALT_INSTR_DEF = 32'h0000_8067;
  localparam logic [31:0] END_MARK_DEF   = 32'hFFFF_0000;

  // Memory-side enable encoding follows whatever MM_ENB_* the memory IO uses.
  localparam logic MM_W = `MM_ENB_W;
  localparam logic MM_R = `MM_ENB_R;

endpackage

// File: rtl/boot_wdog.sv
// Half-rate core clock enable, saturating core-cycle counter and watchdog
// limit compare for the RUN phase.
module boot_wdog #(
  parameter int WDOG_W     = 32,
  parameter int WDOG_LIMIT = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_run,
  input  logic              i_clear,
  input  logic              i_halt,
  output logic              o_ce,
  output logic              o_tick,
  output logic              o_over,
  output logic [WDOG_W-1:0] o_cycles
);

  logic              r_ce;
  logic [WDOG_W-1:0] r_cycles;
  logic              w_tick;
  logic              w_over;

  assign w_tick   = i_run & r_ce;
  assign w_over   = (r_cycles > WDOG_W'(WDOG_LIMIT));
  assign o_ce     = r_ce;
  assign o_tick   = w_tick;
  assign o_over   = w_over;
  assign o_cycles = r_cycles;

  // A tick that times out is not executed, so it is not counted; a halting
  // tick is (halt wins over the watchdog).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ce     <= 1'b0;
      r_cycles <= '0;
    end else begin
      r_ce <= i_run ? ~r_ce : 1'b0;
      if (i_clear) begin
        r_cycles <= '0;
      end else if (w_tick && (i_halt || !w_over) && (r_cycles != {WDOG_W{1'b1}})) begin
        r_cycles <= r_cycles + WDOG_W'(1);
      end
    end
  end

endmodule

// File: rtl/boot_ctrl.sv
// Streams a program image into port A, terminates it, releases the core and
// supervises the run until halt or watchdog timeout.
module boot_ctrl
  import boot_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE       = 32'h0000_0800,
  parameter int          DEPTH      = 1024,
  parameter logic [31:0] HALT_INSTR = HALT_INSTR_DEF,
  parameter logic [31:0] END_MARK   = END_MARK_DEF,
  parameter int          WDOG_W     = 32,
  parameter int          WDOG_LIMIT = 512,
  localparam int         IDX_W      = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [31:0]       ld_data,
  input  logic              ld_last,
  input  logic              restart,
  output logic              mem_enwr,
  output logic [31:0]       mem_abus,
  output logic [31:0]       mem_dbusw,
  input  logic [31:0]       mem_dbusr,
  input  logic [31:0]       core_abus,
  output logic              core_rst,
  output logic              core_ce,
  output logic              done,
  output logic              halted,
  output logic              timeout,
  output logic              ovf,
  output logic [WDOG_W-1:0] cycles,
  output logic [IDX_W-1:0]  words_loaded,
  output boot_state_e       dbg_state
);

  if (DEPTH < 1 || (64'(WDOG_LIMIT) >> WDOG_W) != 64'd0) begin : g_bad_params
    $error("boot_ctrl: DEPTH must be >= 1 and WDOG_LIMIT must fit in WDOG_W bits");
  end

  boot_state_e      r_state;
  logic [IDX_W-1:0] r_idx;
  logic             r_core_rst;
  logic             r_done;
  logic             r_halted;
  logic             r_timeout;
  logic             r_ovf;

  logic             w_hs;
  logic             w_tick;
  logic             w_over;
  logic             w_halt_hit;
  logic             w_clear;
  logic             w_last_slot;
  logic [31:0]      w_wr_addr;

  // Handshake: a word transfers in any cycle where ld_valid && ld_ready;
  // ld_ready is high exactly while in LOAD and never depends on ld_valid.
  assign w_hs        = (r_state == ST_LOAD) && ld_valid;
  assign w_wr_addr   = BASE + (32'(r_idx) << 2);
  assign w_halt_hit  = (mem_dbusr == HALT_INSTR);
  assign w_clear     = (r_state == ST_DONE) && restart;
  assign w_last_slot = (r_idx == IDX_W'(DEPTH - 1));

  assign ld_ready     = (r_state == ST_LOAD);
  assign core_rst     = r_core_rst;
  assign done         = r_done;
  assign halted       = r_halted;
  assign timeout      = r_timeout;
  assign ovf          = r_ovf;
  assign words_loaded = r_idx;
  assign dbg_state    = r_state;

  boot_wdog #(
    .WDOG_W     (WDOG_W),
    .WDOG_LIMIT (WDOG_LIMIT)
  ) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .i_run    (r_state == ST_RUN),
    .i_clear  (w_clear),
    .i_halt   (w_halt_hit),
    .o_ce     (core_ce),
    .o_tick   (w_tick),
    .o_over   (w_over),
    .o_cycles (cycles)
  );

  always_comb begin
    mem_enwr  = MM_R;
    mem_abus  = '0;
    mem_dbusw = '0;
    case (r_state)
      ST_LOAD: begin
        mem_enwr  = w_hs ? MM_W : MM_R;
        mem_abus  = w_wr_addr;
        mem_dbusw = ld_data;
      end
      ST_TERM: begin
        mem_enwr  = MM_W;
        mem_abus  = w_wr_addr;
        mem_dbusw = END_MARK;
      end
      ST_RUN, ST_DONE: mem_abus = core_abus;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_core_rst <= 1'b1;
      r_done     <= 1'b0;
      r_halted   <= 1'b0;
      r_timeout  <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: r_state <= ST_LOAD;
        ST_LOAD: begin
          if (w_hs) begin
            r_idx <= r_idx + IDX_W'(1);
            if (ld_last) begin
              r_state <= ST_TERM;
            end else if (w_last_slot) begin
              r_ovf   <= 1'b1;
              r_state <= ST_TERM;
            end
          end
        end
        ST_TERM: begin
          r_core_rst <= 1'b0;
          r_state    <= ST_RUN;
        end
        ST_RUN: begin
          if (w_tick && w_halt_hit) begin
            r_halted <= 1'b1;
            r_done   <= 1'b1;
            r_state  <= ST_DONE;
          end else if (w_tick && w_over) begin
            r_timeout <= 1'b1;
            r_done    <= 1'b1;
            r_state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (restart) begin
            r_idx      <= '0;
            r_core_rst <= 1'b1;
            r_done     <= 1'b0;
            r_halted   <= 1'b0;
            r_timeout  <= 1'b0;
            r_ovf      <= 1'b0;
            r_state    <= ST_LOAD;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_boot_ctrl.sv
// Directed bench for boot_ctrl with a small DEPTH and watchdog limit so the
// overflow and timeout corners are reachable in a few dozen cycles.
module tb_boot_ctrl;
  import boot_ctrl_pkg::*;

  localparam logic [31:0] HALT = 32'h0000_8067;
  localparam logic [31:0] ENDM = 32'hFFFF_0000;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_valid, ld_ready, ld_last, restart;
  logic [31:0] ld_data;
  logic        mem_enwr;
  logic [31:0] mem_abus, mem_dbusw, mem_dbusr, core_abus;
  logic        core_rst, core_ce, done, halted, timeout, ovf;
  logic [31:0] cycles;
  logic [2:0]  words_loaded;
  boot_state_e dbg_state;

  int n_chk = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];

  boot_ctrl #(.DEPTH(4), .WDOG_LIMIT(8)) dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .ld_last(ld_last), .restart(restart),
    .mem_enwr(mem_enwr), .mem_abus(mem_abus), .mem_dbusw(mem_dbusw),
    .mem_dbusr(mem_dbusr), .core_abus(core_abus), .core_rst(core_rst),
    .core_ce(core_ce), .done(done), .halted(halted), .timeout(timeout),
    .ovf(ovf), .cycles(cycles), .words_loaded(words_loaded), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard: every port-A write must match the next expected {addr,data}
  always @(negedge clk) begin
    if (rst === 1'b1 && mem_enwr === MM_W) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL write_extra: got %h/%h, want no write", mem_abus, mem_dbusw);
      end else begin
        chk("mem_write", {mem_abus, mem_dbusw}, exp_q.pop_front());
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ld_ready"}, 64'(ld_ready), 64'd0);
    chk({tag, "_enwr"}, 64'(mem_enwr), 64'(MM_R));
    chk({tag, "_abus"}, 64'(mem_abus), 64'd0);
    chk({tag, "_dbusw"}, 64'(mem_dbusw), 64'd0);
    chk({tag, "_core_rst"}, 64'(core_rst), 64'd1);
    chk({tag, "_core_ce"}, 64'(core_ce), 64'd0);
    chk({tag, "_flags"}, 64'({done, halted, timeout, ovf}), 64'd0);
    chk({tag, "_cycles"}, 64'(cycles), 64'd0);
    chk({tag, "_words"}, 64'(words_loaded), 64'd0);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_ld_ready"}, 64'(ld_ready), 64'd1);
    chk({tag, "_flags"}, 64'({done, halted, timeout, ovf}), 64'd0);
    chk({tag, "_cycles"}, 64'(cycles), 64'd0);
    chk({tag, "_words"}, 64'(words_loaded), 64'd0);
    chk({tag, "_core_rst"}, 64'(core_rst), 64'd1);
  endtask

  // driver: called at posedge+1; restart is a one-cycle pulse
  task automatic pulse_restart();
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
  endtask

  // Runs the core until done; feeds HALT on the halt_at-th ce cycle (0 = never)
  // and checks done rises one clock after the decide_at-th ce cycle.
  task automatic run_core(input int halt_at, input int decide_at, input string tag);
    int ce_n = 0;
    int decide_c = -1;
    int done_c = -1;
    for (int c = 0; c < 200; c++) begin
      if (done) begin
        done_c = c;
        break;
      end
      if (core_ce) begin
        ce_n++;
        mem_dbusr = (ce_n == halt_at) ? HALT : NOP;
        if (ce_n == decide_at) decide_c = c;
      end else begin
        mem_dbusr = NOP;
      end
      @(posedge clk); #1;
    end
    mem_dbusr = NOP;
    chk({tag, "_done_seen"}, 64'(done_c >= 0), 64'd1);
    chk({tag, "_done_latency"}, 64'(done_c - decide_c), 64'd1);
  endtask

  typedef struct {
    logic        valid;
    logic [31:0] data;
    logic        last;
    logic        exp_ready;
    logic        exp_enwr;
    logic [31:0] exp_abus;
    logic [31:0] exp_dbusw;
    logic        chk_a;
    logic        chk_d;
    logic        exp_core_rst;
    logic [2:0]  exp_words;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int ce_hi;
    rst = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0; restart = 1'b0;
    mem_dbusr = NOP; core_abus = 32'h0000_0900;

    vecs[0] = '{1'b0, 32'h0,  1'b0, 1'b1, MM_R, 32'h0,   32'h0,  1'b0, 1'b0, 1'b1, 3'd0};
    vecs[1] = '{1'b1, 32'h11, 1'b0, 1'b1, MM_W, 32'h800, 32'h11, 1'b1, 1'b1, 1'b1, 3'd0};
    vecs[2] = '{1'b1, 32'h22, 1'b0, 1'b1, MM_W, 32'h804, 32'h22, 1'b1, 1'b1, 1'b1, 3'd1};
    vecs[3] = '{1'b0, 32'h0,  1'b0, 1'b1, MM_R, 32'h0,   32'h0,  1'b0, 1'b0, 1'b1, 3'd2};
    vecs[4] = '{1'b1, 32'h33, 1'b1, 1'b1, MM_W, 32'h808, 32'h33, 1'b1, 1'b1, 1'b1, 3'd2};
    vecs[5] = '{1'b0, 32'h0,  1'b0, 1'b0, MM_W, 32'h80C, ENDM,   1'b1, 1'b1, 1'b1, 3'd3};
    vecs[6] = '{1'b0, 32'h0,  1'b0, 1'b0, MM_R, 32'h900, 32'h0,  1'b1, 1'b0, 1'b0, 3'd3};

    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("por");
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // three-word load, terminator, release into RUN
    exp_q.push_back({32'h800, 32'h11});
    exp_q.push_back({32'h804, 32'h22});
    exp_q.push_back({32'h808, 32'h33});
    exp_q.push_back({32'h80C, ENDM});
    for (int i = 0; i < 7; i++) begin
      ld_valid = vecs[i].valid; ld_data = vecs[i].data; ld_last = vecs[i].last;
      @(negedge clk);
      chk($sformatf("v%0d_ready", i), 64'(ld_ready), 64'(vecs[i].exp_ready));
      chk($sformatf("v%0d_enwr", i), 64'(mem_enwr), 64'(vecs[i].exp_enwr));
      if (vecs[i].chk_a) chk($sformatf("v%0d_abus", i), 64'(mem_abus), 64'(vecs[i].exp_abus));
      if (vecs[i].chk_d) chk($sformatf("v%0d_dbusw", i), 64'(mem_dbusw), 64'(vecs[i].exp_dbusw));
      chk($sformatf("v%0d_core_rst", i), 64'(core_rst), 64'(vecs[i].exp_core_rst));
      chk($sformatf("v%0d_words", i), 64'(words_loaded), 64'(vecs[i].exp_words));
      chk($sformatf("v%0d_core_ce", i), 64'(core_ce), 64'd0);
      @(posedge clk); #1;
    end
    ld_valid = 1'b0; ld_last = 1'b0;

    // halt on the 4th fetched word
    run_core(4, 4, "halt");
    chk("halt_halted", 64'(halted), 64'd1);
    chk("halt_timeout", 64'(timeout), 64'd0);
    chk("halt_cycles", 64'(cycles), 64'd4);
    core_abus = 32'h0000_0A04;
    ce_hi = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (core_ce) ce_hi++;
    end
    chk("halt_ce_held_low", 64'(ce_hi), 64'd0);
    chk("done_core_rst_low", 64'(core_rst), 64'd0);
    chk("done_abus_follows_core", 64'(mem_abus), 64'h0A04);
    chk("done_held", 64'({done, halted}), 64'b11);
    @(posedge clk); #1;

    // restart, then overflow: DEPTH=4, five words, no last
    pulse_restart();
    chk_cleared("restart1");
    for (int i = 0; i < 4; i++) exp_q.push_back({32'h800 + 32'(4 * i), 32'hA0 + 32'(i)});
    exp_q.push_back({32'h810, ENDM});
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1; ld_data = 32'hA0 + 32'(i); ld_last = 1'b0;
      @(posedge clk); #1;
    end
    ld_data = 32'hA4;
    @(negedge clk);
    chk("ovf_flag", 64'(ovf), 64'd1);
    chk("ovf_ld_ready", 64'(ld_ready), 64'd0);
    chk("ovf_words", 64'(words_loaded), 64'd4);
    chk("ovf_term_addr", 64'(mem_abus), 64'h810);
    @(posedge clk); #1;
    ld_valid = 1'b0;

    // program never halts: timeout with cycles = LIMIT+1
    run_core(0, 10, "wdog");
    chk("wdog_timeout", 64'(timeout), 64'd1);
    chk("wdog_halted", 64'(halted), 64'd0);
    chk("wdog_cycles", 64'(cycles), 64'd9);
    chk("wdog_ovf_held", 64'(ovf), 64'd1);

    // halt fetched on the first over-limit tick: halt wins
    pulse_restart();
    chk_cleared("restart2");
    exp_q.push_back({32'h800, 32'h55});
    exp_q.push_back({32'h804, 32'h66});
    exp_q.push_back({32'h808, ENDM});
    ld_valid = 1'b1; ld_data = 32'h55; ld_last = 1'b0;
    @(posedge clk); #1;
    ld_data = 32'h66; ld_last = 1'b1;
    @(posedge clk); #1;
    ld_valid = 1'b0; ld_last = 1'b0;
    run_core(10, 10, "both");
    chk("both_halted", 64'(halted), 64'd1);
    chk("both_timeout", 64'(timeout), 64'd0);
    pulse_restart();
    chk_cleared("restart3");
    chk("restart3_state", 64'(dbg_state), 64'(ST_LOAD));

    // restart outside DONE is ignored; then reset mid-load
    exp_q.push_back({32'h800, 32'h71});
    exp_q.push_back({32'h804, 32'h72});
    ld_valid = 1'b1; ld_data = 32'h71;
    @(posedge clk); #1;
    ld_data = 32'h72;
    @(posedge clk); #1;
    ld_valid = 1'b0;
    pulse_restart();
    chk("ignored_restart_words", 64'(words_loaded), 64'd2);
    chk("ignored_restart_ready", 64'(ld_ready), 64'd1);
    #2 rst = 1'b0;
    #1 chk_reset_vals("midload");
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back({32'h800, 32'h99});
    ld_valid = 1'b1; ld_data = 32'h99;
    @(negedge clk);
    chk("reload_first_addr", 64'(mem_abus), 64'h800);
    @(posedge clk); #1;
    ld_valid = 1'b0;
    chk("reload_words", 64'(words_loaded), 64'd1);

    @(negedge clk);
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
